// File: rtl/sad_seq_ctrl_pkg.sv
// sad_seq_ctrl_pkg: shared FSM state encoding and default block sizing
// for the SAD sequencer.
package sad_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned SAD_N_DEF     = 8;
    localparam int unsigned SAD_ACC_W_DEF = 7;
    localparam int unsigned SAD_CNT_W_DEF = 8;

endpackage

// File: rtl/abs_dif.sv
// abs_dif: purely combinational 4-bit absolute difference, y = |a - b|.
// Ports: a, b (operands), y (result, 0..15).
module abs_dif (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);

    assign y = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/sad_seq_ctrl.sv
// sad_seq_ctrl: drives one shared abs_dif over N operand pairs, accumulates
// the SAD and hands the total out through a valid/ready handshake.
// Ports: clk, rst_n (async, active-low), start, clear (sync abort),
// a_in/b_in/in_valid/in_ready (operand stream), sad/out_valid/out_ready
// (result), busy (ACC or DONE), count (pairs accepted this block).
// Optional: define SAD_MAXDIFF_EN to add max_diff, the largest |a-b| seen.
module sad_seq_ctrl
    import sad_seq_ctrl_pkg::*;
#(
    parameter int unsigned N     = SAD_N_DEF,
    parameter int unsigned ACC_W = SAD_ACC_W_DEF,
    parameter int unsigned CNT_W = SAD_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [3:0]       a_in,
    input  logic [3:0]       b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sad,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] count
`ifdef SAD_MAXDIFF_EN
    ,
    output logic [3:0]       max_diff
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t     state;
    state_t     state_d;
    logic [3:0] diff;
    logic       fire;
    logic       blk_init;

    abs_dif u_abs_dif (
        .a (a_in),
        .b (b_in),
        .y (diff)
    );

    // in_ready is decoded from state, so the handshake reduces to ACC && valid
    assign fire     = (state == ACC) && in_valid;
    assign blk_init = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_d = ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (count == LAST)) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    // sad/count survive the output handshake; only start/clear/reset zero them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sad   <= '0;
            count <= '0;
        end else if (clear || blk_init) begin
            sad   <= '0;
            count <= '0;
        end else if (fire) begin
            sad   <= sad + ACC_W'(diff);
            count <= count + 1'b1;
        end
    end

`ifdef SAD_MAXDIFF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_diff <= '0;
        end else if (clear || blk_init) begin
            max_diff <= '0;
        end else if (fire && (diff > max_diff)) begin
            max_diff <= diff;
        end
    end
`endif

endmodule

// File: tb/tb_sad_seq_ctrl.sv
// tb_sad_seq_ctrl: self-checking bench for sad_seq_ctrl with an N=4 and an
// N=8 instance, checked against a per-block arithmetic reference model.
module tb_sad_seq_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_i[2];
    logic       clear_i[2];
    logic       in_valid_i[2];
    logic       out_ready_i[2];
    logic [3:0] a_i[2];
    logic [3:0] b_i[2];
    logic [5:0] sad4;
    logic [6:0] sad8;
    logic [6:0] sad_o[2];
    logic [7:0] cnt_o[2];
    logic       in_ready_o[2];
    logic       out_valid_o[2];
    logic       busy_o[2];
`ifdef SAD_MAXDIFF_EN
    logic [3:0] maxd_o[2];
`endif

    int checks = 0;
    int errors = 0;
    int exp_sad;
    int exp_cnt;
    int exp_max;
    int qa[$];
    int qb[$];
    int nd[2] = '{4, 8};

    always #5 clk = ~clk;

    sad_seq_ctrl #(.N(4), .ACC_W(6), .CNT_W(8)) u_n4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_i[0]),
        .clear     (clear_i[0]),
        .a_in      (a_i[0]),
        .b_in      (b_i[0]),
        .in_valid  (in_valid_i[0]),
        .in_ready  (in_ready_o[0]),
        .sad       (sad4),
        .out_valid (out_valid_o[0]),
        .out_ready (out_ready_i[0]),
        .busy      (busy_o[0]),
        .count     (cnt_o[0])
`ifdef SAD_MAXDIFF_EN
        ,
        .max_diff  (maxd_o[0])
`endif
    );

    sad_seq_ctrl u_n8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_i[1]),
        .clear     (clear_i[1]),
        .a_in      (a_i[1]),
        .b_in      (b_i[1]),
        .in_valid  (in_valid_i[1]),
        .in_ready  (in_ready_o[1]),
        .sad       (sad8),
        .out_valid (out_valid_o[1]),
        .out_ready (out_ready_i[1]),
        .busy      (busy_o[1]),
        .count     (cnt_o[1])
`ifdef SAD_MAXDIFF_EN
        ,
        .max_diff  (maxd_o[1])
`endif
    );

    assign sad_o[0] = {1'b0, sad4};
    assign sad_o[1] = sad8;

    function automatic int absd(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [2:0] flags(input int d);
        return {busy_o[d], in_ready_o[d], out_valid_o[d]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int d, input string nm);
        checks++;
        if (flags(d) !== 3'b000 || sad_o[d] !== 7'd0 || cnt_o[d] !== 8'd0) begin
            errors++;
            $display("FAIL %s d%0d: got flags=%b sad=%0d cnt=%0d exp flags=000 sad=0 cnt=0",
                     nm, d, flags(d), sad_o[d], cnt_o[d]);
        end
`ifdef SAD_MAXDIFF_EN
        checks++;
        if (maxd_o[d] !== 4'd0) begin
            errors++;
            $display("FAIL %s_max d%0d: got %0d exp 0", nm, d, maxd_o[d]);
        end
`endif
    endtask

    task automatic rand_pairs(input int n);
        qa.delete();
        qb.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back(int'($urandom_range(15, 0)));
            qb.push_back(int'($urandom_range(15, 0)));
        end
    endtask

    task automatic begin_block(input int d);
        exp_sad = 0;
        exp_cnt = 0;
        exp_max = 0;
        start_i[d] = 1'b1;
        tick();
        start_i[d] = 1'b0;
        checks++;
        if (flags(d) !== 3'b110 || sad_o[d] !== 7'd0 || cnt_o[d] !== 8'd0) begin
            errors++;
            $display("FAIL start d%0d: got flags=%b sad=%0d cnt=%0d exp flags=110 sad=0 cnt=0",
                     d, flags(d), sad_o[d], cnt_o[d]);
        end
    endtask

    task automatic feed(input int d, input int npairs, input int stall_max,
                        input bit noise);
        int st;
        for (int i = 0; i < npairs; i++) begin
            st = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
            repeat (st) begin
                in_valid_i[d] = 1'b0;
                a_i[d] = 4'($urandom);
                b_i[d] = 4'($urandom);
                start_i[d] = noise & 1'($urandom);
                tick();
                checks++;
                if (sad_o[d] !== 7'(exp_sad) || cnt_o[d] !== 8'(exp_cnt)) begin
                    errors++;
                    $display("FAIL stall_hold d%0d: got sad=%0d cnt=%0d exp sad=%0d cnt=%0d",
                             d, sad_o[d], cnt_o[d], exp_sad, exp_cnt);
                end
            end
            a_i[d] = 4'(qa[i]);
            b_i[d] = 4'(qb[i]);
            in_valid_i[d] = 1'b1;
            start_i[d] = noise & 1'($urandom);
            tick();
            exp_sad += absd(qa[i], qb[i]);
            exp_cnt++;
            if (absd(qa[i], qb[i]) > exp_max) exp_max = absd(qa[i], qb[i]);
            checks++;
            if (sad_o[d] !== 7'(exp_sad) || cnt_o[d] !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL acc_sum d%0d: got sad=%0d cnt=%0d exp sad=%0d cnt=%0d",
                         d, sad_o[d], cnt_o[d], exp_sad, exp_cnt);
            end
            checks++;
            if (flags(d) !== ((exp_cnt == nd[d]) ? 3'b101 : 3'b110)) begin
                errors++;
                $display("FAIL acc_flags d%0d pair %0d: got %b exp %b", d, exp_cnt,
                         flags(d), (exp_cnt == nd[d]) ? 3'b101 : 3'b110);
            end
`ifdef SAD_MAXDIFF_EN
            checks++;
            if (maxd_o[d] !== 4'(exp_max)) begin
                errors++;
                $display("FAIL acc_max d%0d: got %0d exp %0d", d, maxd_o[d], exp_max);
            end
`endif
        end
        in_valid_i[d] = 1'b0;
        start_i[d] = 1'b0;
    endtask

    task automatic finish_block(input int d, input int hold, input bit noise);
        out_ready_i[d] = 1'b0;
        in_valid_i[d] = 1'b1;
        repeat (hold) begin
            a_i[d] = 4'($urandom);
            b_i[d] = 4'($urandom);
            start_i[d] = noise & 1'($urandom);
            tick();
            checks++;
            if (flags(d) !== 3'b101 || sad_o[d] !== 7'(exp_sad) || cnt_o[d] !== 8'(nd[d])) begin
                errors++;
                $display("FAIL done_hold d%0d: got flags=%b sad=%0d cnt=%0d exp flags=101 sad=%0d cnt=%0d",
                         d, flags(d), sad_o[d], cnt_o[d], exp_sad, nd[d]);
            end
        end
        out_ready_i[d] = 1'b1;
        start_i[d] = noise;
        tick();
        out_ready_i[d] = 1'b0;
        in_valid_i[d] = 1'b0;
        start_i[d] = 1'b0;
        checks++;
        if (flags(d) !== 3'b000 || sad_o[d] !== 7'(exp_sad) || cnt_o[d] !== 8'(nd[d])) begin
            errors++;
            $display("FAIL out_hs d%0d: got flags=%b sad=%0d cnt=%0d exp flags=000 sad=%0d cnt=%0d",
                     d, flags(d), sad_o[d], cnt_o[d], exp_sad, nd[d]);
        end
`ifdef SAD_MAXDIFF_EN
        checks++;
        if (maxd_o[d] !== 4'(exp_max)) begin
            errors++;
            $display("FAIL out_hs_max d%0d: got %0d exp %0d", d, maxd_o[d], exp_max);
        end
`endif
        tick();
        checks++;
        if (flags(d) !== 3'b000) begin
            errors++;
            $display("FAIL idle_after d%0d: got flags=%b exp 000", d, flags(d));
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        check_zero(0, "reset");
        check_zero(1, "reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check_zero(0, "reset_rel");
    endtask

    task automatic test_basic_n4();
        qa = '{9, 2, 15, 5};
        qb = '{3, 7, 0, 5};
        begin_block(0);
        feed(0, 4, 0, 1'b0);
        checks++;
        if (exp_sad != 26 || sad_o[0] !== 7'd26) begin
            errors++;
            $display("FAIL basic_26: got %0d exp 26", sad_o[0]);
        end
        finish_block(0, 2, 1'b0);
    endtask

    task automatic test_max_n8();
        qa = '{15, 15, 15, 15, 15, 15, 15, 15};
        qb = '{0, 0, 0, 0, 0, 0, 0, 0};
        begin_block(1);
        feed(1, 8, 0, 1'b0);
        checks++;
        if (sad_o[1] !== 7'd120 || cnt_o[1] !== 8'd8) begin
            errors++;
            $display("FAIL max_120: got sad=%0d cnt=%0d exp sad=120 cnt=8",
                     sad_o[1], cnt_o[1]);
        end
        finish_block(1, 1, 1'b0);
    endtask

    task automatic test_stall();
        rand_pairs(4);
        begin_block(0);
        feed(0, 4, 2, 1'b0);
        finish_block(0, 5, 1'b0);
    endtask

    task automatic test_reset_mid();
        rand_pairs(4);
        begin_block(0);
        feed(0, 2, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_zero(0, "reset_mid");
        #1 rst_n = 1'b1;
        rand_pairs(4);
        begin_block(0);
        feed(0, 4, 1, 1'b0);
        finish_block(0, 1, 1'b0);
    endtask

    task automatic test_clear();
        rand_pairs(4);
        begin_block(0);
        feed(0, 3, 0, 1'b0);
        clear_i[0] = 1'b1;
        in_valid_i[0] = 1'b1;
        a_i[0] = 4'd15;
        b_i[0] = 4'd0;
        tick();
        in_valid_i[0] = 1'b0;
        check_zero(0, "clear_acc");
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        clear_i[0] = 1'b0;
        check_zero(0, "clear_start");
        tick();
        check_zero(0, "clear_idle");
        rand_pairs(4);
        begin_block(0);
        feed(0, 4, 0, 1'b0);
        clear_i[0] = 1'b1;
        tick();
        clear_i[0] = 1'b0;
        check_zero(0, "clear_done");
    endtask

    task automatic test_start_noise();
        rand_pairs(8);
        begin_block(1);
        feed(1, 8, 2, 1'b1);
        finish_block(1, 3, 1'b1);
    endtask

    task automatic test_random();
        int d;
        for (int k = 0; k < 20; k++) begin
            d = k % 2;
            rand_pairs(nd[d]);
            begin_block(d);
            feed(d, nd[d], int'($urandom_range(3, 0)), 1'($urandom));
            finish_block(d, int'($urandom_range(4, 0)), 1'($urandom));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_i[d] = 1'b0;
            clear_i[d] = 1'b0;
            in_valid_i[d] = 1'b0;
            out_ready_i[d] = 1'b0;
            a_i[d] = 4'd0;
            b_i[d] = 4'd0;
        end
        test_reset();
        test_basic_n4();
        test_max_n8();
        test_stall();
        test_reset_mid();
        test_clear();
        test_start_noise();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
